// File: rtl/mips_pipe_pkg.sv
// Shared pipeline definitions for the 5-stage MIPS core: default field widths,
// control-bit positions and the packed payload width helper.
package mips_pipe_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;
    localparam int CTRL_W = 5;

    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_MEMREAD  = 3;
    localparam int CTRL_MEMWRITE = 2;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWRITE = 0;

    localparam int PAYLOAD_W = 1 + 2*DATA_W + ADDR_W + 2*REG_W + CTRL_W;

    function automatic int payload_width(input int dw, input int aw, input int rw, input int cw);
        return 1 + 2*dw + aw + 2*rw + cw;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: a main register driving the outputs plus a skid
// register that absorbs one bundle of backpressure, so in_ready_o is registered.
module pipe_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [W-1:0] in_data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [W-1:0] out_data_o
);

    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         main_valid_q, main_valid_d;
    logic         skid_valid_q, skid_valid_d;
    logic         ready_q;
    logic         accept, retire, main_free;

    assign accept    = in_valid_i & ready_q;
    assign retire    = main_valid_q & out_ready_i;
    assign main_free = ~main_valid_q | retire;

    always_comb begin
        // NOTE: every next-state signal gets a default first, so no path leaves one unassigned (no latch).
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q & ~retire;
        skid_valid_d = skid_valid_q;

        if (main_free) begin
            if (skid_valid_q) begin
                // The skid entry is older than anything on the input, so it goes first.
                main_d       = skid_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d       = in_data_i;
                main_valid_d = 1'b1;
            end
        end else if (accept) begin
            skid_d       = in_data_i;
            skid_valid_d = 1'b1;
        end

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (rst) begin
            // NOTE: payload registers are cleared as well, so the data outputs read 0 rather than X after reset.
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ~skid_valid_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with valid/ready handshake, skid buffering and flush.
// Control bits and the branch decision are suppressed whenever the stage holds a bubble.
module ex_mem_pipe_stage #(
    parameter int DATA_W = mips_pipe_pkg::DATA_W,
    parameter int ADDR_W = mips_pipe_pkg::ADDR_W,
    parameter int REG_W  = mips_pipe_pkg::REG_W,
    parameter int CTRL_W = mips_pipe_pkg::CTRL_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_W-1:0]  ex_rt,
    input  logic [ADDR_W-1:0] ex_branch_addr,
    input  logic [REG_W-1:0]  ex_reg_dest,
    input  logic [CTRL_W-1:0] ex_ctrl,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_zero,
    output logic [DATA_W-1:0] mem_alu_result,
    output logic [DATA_W-1:0] mem_store_data,
    output logic [REG_W-1:0]  mem_rt,
    output logic [ADDR_W-1:0] mem_branch_addr,
    output logic [REG_W-1:0]  mem_reg_dest,
    output logic [CTRL_W-1:0] mem_ctrl,
    output logic              mem_pc_src
);

    import mips_pipe_pkg::*;

    localparam int PW = payload_width(DATA_W, ADDR_W, REG_W, CTRL_W);

    logic [PW-1:0]     in_payload, out_payload;
    logic [CTRL_W-1:0] ctrl_raw;

    assign in_payload = {ex_zero, ex_alu_result, ex_store_data, ex_rt,
                         ex_branch_addr, ex_reg_dest, ex_ctrl};

    pipe_skid_buf #(.W(PW)) u_skid (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .in_valid_i  (ex_valid),
        .in_ready_o  (ex_ready),
        .in_data_i   (in_payload),
        .out_valid_o (mem_valid),
        .out_ready_i (mem_ready),
        .out_data_o  (out_payload)
    );

    assign {mem_zero, mem_alu_result, mem_store_data, mem_rt,
            mem_branch_addr, mem_reg_dest, ctrl_raw} = out_payload;

    assign mem_ctrl   = mem_valid ? ctrl_raw : '0;
    assign mem_pc_src = mem_valid & ctrl_raw[CTRL_BRANCH] & mem_zero;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Self-checking bench for ex_mem_pipe_stage: a FIFO-occupancy model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_ex_mem_pipe_stage;

    typedef struct packed {
        logic        zero;
        logic [31:0] alu;
        logic [31:0] store;
        logic [4:0]  rt;
        logic [31:0] baddr;
        logic [4:0]  rdest;
        logic [4:0]  ctrl;
    } item_t;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, ex_ready, ex_zero, mem_valid, mem_ready;
    logic [31:0] ex_alu_result, ex_store_data, ex_branch_addr;
    logic [4:0]  ex_rt, ex_reg_dest, ex_ctrl;
    logic        mem_zero, mem_pc_src;
    logic [31:0] mem_alu_result, mem_store_data, mem_branch_addr;
    logic [4:0]  mem_rt, mem_reg_dest, mem_ctrl;

    int n_tests = 0;
    int n_fail  = 0;
    bit armed   = 1'b0;

    item_t       model_q[$];
    logic [31:0] retired[$];

    always #5 clk = ~clk;

    ex_mem_pipe_stage dut (
        .clk(clk), .rst(rst), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_zero(ex_zero),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data), .ex_rt(ex_rt),
        .ex_branch_addr(ex_branch_addr), .ex_reg_dest(ex_reg_dest), .ex_ctrl(ex_ctrl),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_zero(mem_zero),
        .mem_alu_result(mem_alu_result), .mem_store_data(mem_store_data), .mem_rt(mem_rt),
        .mem_branch_addr(mem_branch_addr), .mem_reg_dest(mem_reg_dest),
        .mem_ctrl(mem_ctrl), .mem_pc_src(mem_pc_src)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic item_t mk(input logic [31:0] alu, input logic [4:0] ctrl,
                                 input logic zero, input logic [31:0] baddr);
        item_t it;
        it.zero  = zero;
        it.alu   = alu;
        it.store = ~alu;
        it.rt    = alu[6:2];
        it.baddr = baddr;
        it.rdest = alu[4:0] ^ 5'h1F;
        it.ctrl  = ctrl;
        return it;
    endfunction

    task automatic drive(input logic v, input item_t it, input logic mr, input logic fl);
        ex_valid       = v;
        ex_zero        = it.zero;
        ex_alu_result  = it.alu;
        ex_store_data  = it.store;
        ex_rt          = it.rt;
        ex_branch_addr = it.baddr;
        ex_reg_dest    = it.rdest;
        ex_ctrl        = it.ctrl;
        mem_ready      = mr;
        flush          = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: the stage is a FIFO of depth 2; ready means fewer than two bundles held.
    always @(posedge clk) begin : model
        bit rdy;
        if (rst) begin
            model_q.delete();
            armed = 1'b1;
        end else begin
            rdy = (model_q.size() < 2);
            if (model_q.size() > 0 && mem_ready) begin
                retired.push_back(model_q[0].alu);
                void'(model_q.pop_front());
            end
            if (flush)
                model_q.delete();
            else if (ex_valid && rdy)
                model_q.push_back('{ex_zero, ex_alu_result, ex_store_data, ex_rt,
                                    ex_branch_addr, ex_reg_dest, ex_ctrl});
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("mem_valid", 64'(mem_valid), 64'(model_q.size() > 0));
            check("ex_ready", 64'(ex_ready), 64'(model_q.size() < 2));
            if (model_q.size() > 0) begin
                check("mem_zero", 64'(mem_zero), 64'(model_q[0].zero));
                check("mem_alu_result", 64'(mem_alu_result), 64'(model_q[0].alu));
                check("mem_store_data", 64'(mem_store_data), 64'(model_q[0].store));
                check("mem_rt", 64'(mem_rt), 64'(model_q[0].rt));
                check("mem_branch_addr", 64'(mem_branch_addr), 64'(model_q[0].baddr));
                check("mem_reg_dest", 64'(mem_reg_dest), 64'(model_q[0].rdest));
                check("mem_ctrl", 64'(mem_ctrl), 64'(model_q[0].ctrl));
                check("mem_pc_src", 64'(mem_pc_src), 64'(model_q[0].ctrl[4] & model_q[0].zero));
            end else begin
                check("bubble_ctrl", 64'(mem_ctrl), 64'h0);
                check("bubble_pc_src", 64'(mem_pc_src), 64'h0);
            end
        end
    end

    initial begin
        logic [31:0] exp_ret [8];
        item_t       idle;
        int          n_dir;

        exp_ret = '{32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30, 32'h70, 32'h80};
        idle    = mk(32'h0, 5'b0, 1'b0, 32'h0);

        // Reset with EX offering a bundle: nothing may be captured.
        rst = 1'b1;
        drive(1'b1, mk(32'hDEAD_BEEF, 5'b11111, 1'b1, 32'h1234), 1'b1, 1'b0);
        step();
        step();
        check("rst_mem_valid", 64'(mem_valid), 64'h0);
        check("rst_mem_ctrl", 64'(mem_ctrl), 64'h0);
        check("rst_ex_ready", 64'(ex_ready), 64'h1);
        check("rst_alu_zero", 64'(mem_alu_result), 64'h0);
        check("rst_pc_src", 64'(mem_pc_src), 64'h0);
        rst = 1'b0;
        drive(1'b0, idle, 1'b1, 1'b0);
        step();
        check("post_rst_empty", 64'(mem_valid), 64'h0);

        // Back-to-back stream with MEM always ready.
        drive(1'b1, mk(32'h10, 5'b01001, 1'b0, 32'h0), 1'b1, 1'b0);
        step();
        check("stream_0x10", 64'(mem_alu_result), 64'h10);
        drive(1'b1, mk(32'h20, 5'b01001, 1'b0, 32'h0), 1'b1, 1'b0);
        step();
        check("stream_0x20", 64'(mem_alu_result), 64'h20);
        check("stream_ready", 64'(ex_ready), 64'h1);
        drive(1'b1, mk(32'h30, 5'b01001, 1'b0, 32'h0), 1'b1, 1'b0);
        step();
        check("stream_0x30", 64'(mem_alu_result), 64'h30);
        check("stream_valid", 64'(mem_valid), 64'h1);
        drive(1'b0, idle, 1'b1, 1'b0);
        step();
        check("stream_drained", 64'(mem_valid), 64'h0);

        // Backpressure: 0x20 lands in skid, 0x30 is held off by ex_ready=0.
        drive(1'b1, mk(32'h10, 5'b00110, 1'b0, 32'h0), 1'b1, 1'b0);
        step();
        drive(1'b1, mk(32'h20, 5'b00110, 1'b0, 32'h0), 1'b0, 1'b0);
        step();
        check("bp_main_0x10", 64'(mem_alu_result), 64'h10);
        check("bp_ready_low", 64'(ex_ready), 64'h0);
        drive(1'b1, mk(32'h30, 5'b00110, 1'b0, 32'h0), 1'b0, 1'b0);
        step();
        check("bp_hold_0x10", 64'(mem_alu_result), 64'h10);
        drive(1'b1, mk(32'h30, 5'b00110, 1'b0, 32'h0), 1'b1, 1'b0);
        step();
        check("bp_skid_0x20", 64'(mem_alu_result), 64'h20);
        check("bp_ready_back", 64'(ex_ready), 64'h1);
        step();
        check("bp_last_0x30", 64'(mem_alu_result), 64'h30);
        drive(1'b0, idle, 1'b1, 1'b0);
        step();
        check("bp_drained", 64'(mem_valid), 64'h0);

        // Flush with both entries full and a new bundle offered.
        drive(1'b1, mk(32'h40, 5'b01011, 1'b0, 32'h0), 1'b0, 1'b0);
        step();
        drive(1'b1, mk(32'h50, 5'b01011, 1'b0, 32'h0), 1'b0, 1'b0);
        step();
        check("fl_full_ready", 64'(ex_ready), 64'h0);
        drive(1'b1, mk(32'h60, 5'b01011, 1'b0, 32'h0), 1'b0, 1'b1);
        step();
        check("fl_valid", 64'(mem_valid), 64'h0);
        check("fl_ctrl", 64'(mem_ctrl), 64'h0);
        check("fl_ready", 64'(ex_ready), 64'h1);
        drive(1'b0, idle, 1'b1, 1'b0);
        step();
        step();
        check("fl_stays_empty", 64'(mem_valid), 64'h0);

        // Branch decision: not-taken, taken, then bubble with zero flag held.
        drive(1'b1, mk(32'h70, 5'b10000, 1'b0, 32'h0040_0100), 1'b1, 1'b0);
        step();
        check("br_zero0_pc_src", 64'(mem_pc_src), 64'h0);
        drive(1'b1, mk(32'h80, 5'b10000, 1'b1, 32'h0040_0100), 1'b1, 1'b0);
        step();
        check("br_taken_pc_src", 64'(mem_pc_src), 64'h1);
        check("br_target", 64'(mem_branch_addr), 64'h0040_0100);
        drive(1'b0, idle, 1'b1, 1'b0);
        step();
        check("br_bubble_pc_src", 64'(mem_pc_src), 64'h0);
        check("br_bubble_ctrl", 64'(mem_ctrl), 64'h0);
        check("br_bubble_zero_held", 64'(mem_zero), 64'h1);

        n_dir = retired.size();
        check("dir_retire_count", 64'(n_dir), 64'd8);
        for (int i = 0; i < n_dir && i < 8; i++)
            check("dir_retire_order", 64'(retired[i]), 64'(exp_ret[i]));

        // Randomised traffic; the per-cycle compare covers loss, duplication and ready timing.
        for (int c = 0; c < 400; c++) begin
            item_t it;
            it = '{zero: 1'($urandom), alu: $urandom, store: $urandom, rt: 5'($urandom),
                   baddr: $urandom, rdest: 5'($urandom), ctrl: 5'($urandom)};
            drive($urandom_range(0, 9) < 7, it, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 19) == 0);
            step();
        end
        drive(1'b0, idle, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) step();
        check("final_empty", 64'(mem_valid), 64'h0);
        check("final_ready", 64'(ex_ready), 64'h1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
